// File: rtl/tpu_sequencer_if.sv
// Host/memory/feeder signal bundle for tpu_sequencer.
// The slave modport is the sequencer's view; the master modport is the host/testbench view.
interface tpu_sequencer_if #(
    parameter int DATA_W = 8
);
    logic              host_valid;
    logic [DATA_W-1:0] host_data;
    logic              host_ready;
    logic              soft_clr;
    logic              keep_weights;
    logic              mem_we;
    logic              mem_sel;
    logic [1:0]        mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              feeder_en;
    logic [2:0]        mmu_cycles;
    logic              out_valid;
    logic [1:0]        out_idx;
    logic              busy;
    logic              done;

    modport slave (
        input  host_valid, host_data, soft_clr, keep_weights,
        output host_ready, mem_we, mem_sel, mem_addr, mem_wdata,
               feeder_en, mmu_cycles, out_valid, out_idx, busy, done
    );

    modport master (
        output host_valid, host_data, soft_clr, keep_weights,
        input  host_ready, mem_we, mem_sel, mem_addr, mem_wdata,
               feeder_en, mmu_cycles, out_valid, out_idx, busy, done
    );
endinterface

// File: rtl/tpu_sequencer.sv
// Job controller for the 2x2 systolic matmul: loads 4 weights + 4 inputs, then runs one feeder pass.
// Optional weight reuse (keep_weights) is built when TPU_SEQ_WEIGHT_REUSE_EN is defined.
module tpu_sequencer #(
    parameter int DATA_W     = 8,
    parameter int LAST_CYCLE = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    tpu_sequencer_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_LOAD_I,
        S_COMPUTE,
        S_DRAIN
    } state_e;

    state_e     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic [2:0] cyc_q, cyc_d;
    logic       ov_q, ov_d;
    logic [1:0] oidx_q, oidx_d;
    logic       ready;
    logic       xfer;
    logic       reuse;
    logic       sel;
    logic [1:0] addr;

`ifdef TPU_SEQ_WEIGHT_REUSE_EN
    logic wl_q, wl_d;

    // keep_weights only matters on the IDLE transfer that starts a job
    assign reuse = bus.keep_weights & wl_q;

    always_comb begin
        wl_d = wl_q;
        if (bus.soft_clr)
            wl_d = 1'b0;
        else if (state_q == S_LOAD_W && xfer && cnt_q == 2'd3)
            wl_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wl_q <= 1'b0;
        else        wl_q <= wl_d;
    end
`else
    logic unused_keep_weights;
    assign unused_keep_weights = bus.keep_weights;
    assign reuse = 1'b0;
`endif

    assign ready = (state_q == S_IDLE) || (state_q == S_LOAD_W) || (state_q == S_LOAD_I);
    assign xfer  = bus.host_valid & ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cyc_d   = cyc_q;
        ov_d    = 1'b0;
        oidx_d  = 2'd0;
        sel     = 1'b0;
        addr    = cnt_q;
        case (state_q)
            S_IDLE: begin
                addr = 2'd0;
                sel  = reuse;
                if (xfer) begin
                    state_d = reuse ? S_LOAD_I : S_LOAD_W;
                    cnt_d   = 2'd1;
                end
            end
            S_LOAD_W: begin
                if (xfer) begin
                    if (cnt_q == 2'd3) begin
                        state_d = S_LOAD_I;
                        cnt_d   = 2'd0;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end
            S_LOAD_I: begin
                sel = 1'b1;
                if (xfer) begin
                    if (cnt_q == 2'd3) begin
                        state_d = S_COMPUTE;
                        cnt_d   = 2'd0;
                        cyc_d   = 3'd0;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end
            S_COMPUTE: begin
                // feeder result register lags mmu_cycles by one, so flag it next cycle
                if (cyc_q >= 3'd2) begin
                    ov_d   = 1'b1;
                    oidx_d = 2'(cyc_q - 3'd2);
                end
                if (cyc_q == 3'(LAST_CYCLE)) begin
                    state_d = S_DRAIN;
                    cyc_d   = 3'd0;
                end else begin
                    cyc_d = cyc_q + 3'd1;
                end
            end
            S_DRAIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 2'd0;
                cyc_d   = 3'd0;
            end
        endcase
        if (bus.soft_clr) begin
            state_d = S_IDLE;
            cnt_d   = 2'd0;
            cyc_d   = 3'd0;
            ov_d    = 1'b0;
            oidx_d  = 2'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 2'd0;
            cyc_q   <= 3'd0;
            ov_q    <= 1'b0;
            oidx_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cyc_q   <= cyc_d;
            ov_q    <= ov_d;
            oidx_q  <= oidx_d;
        end
    end

    assign bus.host_ready = ready;
    assign bus.mem_we     = xfer;
    assign bus.mem_sel    = sel;
    assign bus.mem_addr   = addr;
    assign bus.mem_wdata  = bus.host_data;
    assign bus.feeder_en  = (state_q == S_COMPUTE);
    assign bus.mmu_cycles = cyc_q;
    assign bus.out_valid  = ov_q;
    assign bus.out_idx    = oidx_q;
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.done       = (state_q == S_DRAIN);

endmodule

// File: tb/tb_tpu_sequencer.sv
// Directed bench for tpu_sequencer: a per-cycle vector table for one full pass,
// then hand-written sequences for gaps, back-pressure, soft_clr, mid-pass reset and weight reuse.
module tb_tpu_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    tpu_sequencer_if #(.DATA_W(8)) bus ();

    tpu_sequencer #(.DATA_W(8), .LAST_CYCLE(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory write recorder
    logic [7:0] wmem [4];
    logic [7:0] imem [4];
    int wcount = 0;
    int nsel0  = 0;
    int first_sel  = -1;
    int first_addr = -1;

    always @(posedge clk) begin
        if (bus.mem_we) begin
            if (wcount == 0) begin
                first_sel  = int'(bus.mem_sel);
                first_addr = int'(bus.mem_addr);
            end
            if (!bus.mem_sel) begin
                wmem[bus.mem_addr] = bus.mem_wdata;
                nsel0++;
            end else begin
                imem[bus.mem_addr] = bus.mem_wdata;
            end
            wcount++;
        end
    end

    task automatic clr_log();
        wcount = 0; nsel0 = 0; first_sel = -1; first_addr = -1;
    endtask

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       rdy, we, sel;
        logic [1:0] addr;
        logic       en;
        logic [2:0] cyc;
        logic       ov;
        logic [1:0] idx;
        logic       busy, done;
    } vec_t;

    function automatic vec_t mk(logic v, logic [7:0] d, logic rdy, logic we, logic sel,
                                logic [1:0] addr, logic en, logic [2:0] cyc, logic ov,
                                logic [1:0] idx, logic busy, logic done);
        vec_t r;
        r.v = v; r.d = d; r.rdy = rdy; r.we = we; r.sel = sel; r.addr = addr;
        r.en = en; r.cyc = cyc; r.ov = ov; r.idx = idx; r.busy = busy; r.done = done;
        return r;
    endfunction

    // Sends n bytes starting at base; returns at the sample point of the cycle after the last transfer.
    task automatic send_bytes(input int n, input logic [7:0] base, input bit gap);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            bus.host_valid = 1'b1;
            bus.host_data  = base + 8'(k);
            #1;
            chk($sformatf("send[%0d].ready", k), bus.host_ready, 1);
            if (gap && k < n - 1) begin
                @(negedge clk);
                bus.host_valid = 1'b0;
                #1;
                chk($sformatf("gap[%0d].we", k), bus.mem_we, 0);
                chk($sformatf("gap[%0d].ready", k), bus.host_ready, 1);
                chk($sformatf("gap[%0d].en", k), bus.feeder_en, 0);
            end
        end
        @(negedge clk);
        bus.host_valid = 1'b0;
        #1;
    endtask

    // Starts at the sample point of COMPUTE cycle 0; follows the pass to IDLE with a cycle budget.
    task automatic run_compute(input string tag);
        int nov  = 0;
        bit seen = 0;
        for (int i = 0; i < 12 && !seen; i++) begin
            if (i > 0) begin @(negedge clk); #1; end
            chk({tag, ".ready"}, bus.host_ready, 0);
            chk({tag, ".we"}, bus.mem_we, 0);
            if (bus.out_valid) begin
                chk($sformatf("%s.idx%0d", tag, nov), bus.out_idx, nov);
                nov++;
            end
            if (bus.done) begin
                seen = 1;
                chk({tag, ".done_ov_idx3"}, {bus.out_valid, bus.out_idx, bus.feeder_en}, {1'b1, 2'd3, 1'b0});
            end else if (i <= 5) begin
                chk($sformatf("%s.cyc%0d", tag, i), {bus.feeder_en, bus.mmu_cycles}, {1'b1, 3'(i)});
            end
        end
        chk({tag, ".done_seen"}, seen, 1);
        chk({tag, ".nov"}, nov, 4);
        @(negedge clk); #1;
        chk({tag, ".idle_busy"}, bus.busy, 0);
        chk({tag, ".idle_ov"}, bus.out_valid, 0);
    endtask

    vec_t tbl [16];

    initial begin
        tbl[0]  = mk(1, 8'd1, 1, 1, 0, 2'd0, 0, 3'd0, 0, 2'd0, 0, 0);
        tbl[1]  = mk(1, 8'd2, 1, 1, 0, 2'd1, 0, 3'd0, 0, 2'd0, 1, 0);
        tbl[2]  = mk(1, 8'd3, 1, 1, 0, 2'd2, 0, 3'd0, 0, 2'd0, 1, 0);
        tbl[3]  = mk(1, 8'd4, 1, 1, 0, 2'd3, 0, 3'd0, 0, 2'd0, 1, 0);
        tbl[4]  = mk(1, 8'd5, 1, 1, 1, 2'd0, 0, 3'd0, 0, 2'd0, 1, 0);
        tbl[5]  = mk(1, 8'd6, 1, 1, 1, 2'd1, 0, 3'd0, 0, 2'd0, 1, 0);
        tbl[6]  = mk(1, 8'd7, 1, 1, 1, 2'd2, 0, 3'd0, 0, 2'd0, 1, 0);
        tbl[7]  = mk(1, 8'd8, 1, 1, 1, 2'd3, 0, 3'd0, 0, 2'd0, 1, 0);
        tbl[8]  = mk(0, 8'd0, 0, 0, 0, 2'd0, 1, 3'd0, 0, 2'd0, 1, 0);
        tbl[9]  = mk(0, 8'd0, 0, 0, 0, 2'd0, 1, 3'd1, 0, 2'd0, 1, 0);
        tbl[10] = mk(0, 8'd0, 0, 0, 0, 2'd0, 1, 3'd2, 0, 2'd0, 1, 0);
        tbl[11] = mk(0, 8'd0, 0, 0, 0, 2'd0, 1, 3'd3, 1, 2'd0, 1, 0);
        tbl[12] = mk(0, 8'd0, 0, 0, 0, 2'd0, 1, 3'd4, 1, 2'd1, 1, 0);
        tbl[13] = mk(0, 8'd0, 0, 0, 0, 2'd0, 1, 3'd5, 1, 2'd2, 1, 0);
        tbl[14] = mk(0, 8'd0, 0, 0, 0, 2'd0, 0, 3'd0, 1, 2'd3, 1, 1);
        tbl[15] = mk(0, 8'd0, 1, 0, 0, 2'd0, 0, 3'd0, 0, 2'd0, 0, 0);

        rst_n = 1'b0;
        bus.host_valid = 1'b0; bus.host_data = 8'h00;
        bus.soft_clr = 1'b0;   bus.keep_weights = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset.outs", {bus.host_ready, bus.mem_we, bus.mem_sel, bus.mem_addr, bus.feeder_en,
                           bus.mmu_cycles, bus.out_valid, bus.out_idx, bus.busy, bus.done},
                          {1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 3'd0, 1'b0, 2'd0, 1'b0, 1'b0});
        @(negedge clk);
        rst_n = 1'b1;

        // 1: back-to-back full pass, cycle-accurate table
        clr_log();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            bus.host_valid = tbl[i].v;
            bus.host_data  = tbl[i].d;
            #1;
            chk($sformatf("t1[%0d].rdy", i),  bus.host_ready, tbl[i].rdy);
            chk($sformatf("t1[%0d].we", i),   bus.mem_we,     tbl[i].we);
            chk($sformatf("t1[%0d].sel", i),  bus.mem_sel,    tbl[i].sel);
            chk($sformatf("t1[%0d].addr", i), bus.mem_addr,   tbl[i].addr);
            chk($sformatf("t1[%0d].en", i),   bus.feeder_en,  tbl[i].en);
            chk($sformatf("t1[%0d].cyc", i),  bus.mmu_cycles, tbl[i].cyc);
            chk($sformatf("t1[%0d].ov", i),   bus.out_valid,  tbl[i].ov);
            chk($sformatf("t1[%0d].idx", i),  bus.out_idx,    tbl[i].idx);
            chk($sformatf("t1[%0d].busy", i), bus.busy,       tbl[i].busy);
            chk($sformatf("t1[%0d].done", i), bus.done,       tbl[i].done);
            if (tbl[i].we) chk($sformatf("t1[%0d].wdata", i), bus.mem_wdata, tbl[i].d);
        end
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t1.w%0d", i), wmem[i], 8'(i + 1));
            chk($sformatf("t1.i%0d", i), imem[i], 8'(i + 5));
        end
        chk("t1.wcount", wcount, 8);

        // 2: gaps between bytes
        clr_log();
        send_bytes(8, 8'h10, 1'b1);
        chk("t2.wcount", wcount, 8);
        chk("t2.compute_start", {bus.feeder_en, bus.mmu_cycles}, {1'b1, 3'd0});
        run_compute("t2");
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t2.w%0d", i), wmem[i], 8'h10 + 8'(i));
            chk($sformatf("t2.i%0d", i), imem[i], 8'h14 + 8'(i));
        end

        // 3: host holds 0xAA through COMPUTE/DRAIN
        clr_log();
        send_bytes(8, 8'h20, 1'b0);
        bus.host_valid = 1'b1;
        bus.host_data  = 8'hAA;
        run_compute("t3");
        chk("t3.wcount", wcount, 8);
        chk("t3.accept_in_idle", {bus.host_ready, bus.mem_we, bus.mem_sel, bus.mem_addr}, {1'b1, 1'b1, 1'b0, 2'd0});
        @(negedge clk);
        bus.host_valid = 1'b0;
        bus.soft_clr   = 1'b1;
        #1;
        chk("t3.in_loadw", bus.busy, 1);
        @(negedge clk);
        bus.soft_clr = 1'b0;
        #1;
        chk("t3.cleared", bus.busy, 0);

        // 4: soft_clr at mmu_cycles=3
        send_bytes(8, 8'h30, 1'b0);
        repeat (3) begin @(negedge clk); #1; end
        chk("t4.at_cyc3", {bus.feeder_en, bus.mmu_cycles}, {1'b1, 3'd3});
        bus.soft_clr = 1'b1;
        @(negedge clk);
        bus.soft_clr = 1'b0;
        #1;
        chk("t4.after_clr", {bus.busy, bus.feeder_en, bus.mmu_cycles, bus.out_valid, bus.done, bus.host_ready},
                            {1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1});
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            chk($sformatf("t4.quiet%0d", i), {bus.done, bus.out_valid, bus.busy}, 3'b000);
        end
        clr_log();
        send_bytes(8, 8'h38, 1'b0);
        chk("t4.rerun_wcount", wcount, 8);
        run_compute("t4");

        // 5: reset after 5 bytes, then a clean job
        send_bytes(5, 8'h50, 1'b0);
        chk("t5.mid_load", {bus.busy, bus.mem_sel}, 2'b11);
        rst_n = 1'b0;
        #1;
        chk("t5.async_rst", {bus.busy, bus.host_ready}, 2'b01);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clr_log();
        send_bytes(8, 8'h40, 1'b0);
        chk("t5.first_write", {first_sel[0], first_addr[1:0]}, 3'b000);
        chk("t5.wcount", wcount, 8);
        run_compute("t5");
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t5.w%0d", i), wmem[i], 8'h40 + 8'(i));
            chk($sformatf("t5.i%0d", i), imem[i], 8'h44 + 8'(i));
        end

        // 6: keep_weights
        bus.keep_weights = 1'b1;
        clr_log();
`ifdef TPU_SEQ_WEIGHT_REUSE_EN
        send_bytes(4, 8'h60, 1'b0);
        chk("t6.reuse_wcount", wcount, 4);
        chk("t6.reuse_no_w", nsel0, 0);
        chk("t6.reuse_compute", bus.feeder_en, 1);
        run_compute("t6a");
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t6.w%0d_kept", i), wmem[i], 8'h40 + 8'(i));
            chk($sformatf("t6.i%0d", i), imem[i], 8'h60 + 8'(i));
        end
        @(negedge clk);
        bus.soft_clr = 1'b1;
        @(negedge clk);
        bus.soft_clr = 1'b0;
        clr_log();
        send_bytes(4, 8'h70, 1'b0);
        chk("t6.clr_still_loading", {bus.feeder_en, bus.busy}, 2'b01);
        chk("t6.clr_w_writes", nsel0, 4);
        send_bytes(4, 8'h74, 1'b0);
        chk("t6.clr_wcount", wcount, 8);
        run_compute("t6b");
`else
        send_bytes(4, 8'h60, 1'b0);
        chk("t6.ignored_still_loading", {bus.feeder_en, bus.busy}, 2'b01);
        chk("t6.ignored_w_writes", nsel0, 4);
        send_bytes(4, 8'h64, 1'b0);
        chk("t6.ignored_wcount", wcount, 8);
        run_compute("t6");
`endif
        bus.keep_weights = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
